exec_issue_ctrl: RTL and testbench
==================================

# exec_issue_ctrl

Issue controller for the two-stage execute datapath (execute preprocessor followed by the ALU). It buffers decoded operations in a small FIFO and issues at most one per cycle by driving `enable_ex`, `control_in` and the operand buses. It also stalls on read-after-write hazards against operations still in flight, and tags each ALU result with its destination register when `aluout` becomes valid.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `LATENCY`, 2: cycles from issue to a valid `aluout` (preprocessor register + ALU register).
- `REGISTER_WIDTH`, 32: operand and result width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `flush`  in  1  synchronous; discards queued and in-flight operations.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  FIFO can accept.
- `in_control`  in  7  execute control word, passed through unchanged.
- `in_src1`, `in_src2`, `in_imm`  in  REGISTER_WIDTH each  operands.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  destination and source register indices.
- `in_rs_used`  in  2  bit0: rs1 read; bit1: rs2 read.
- `enable_ex`  out  1  issue strobe to the execute stage.
- `control_out`  out  7  control word of the issued operation.
- `src1_out`, `src2_out`, `imm_out`  out  REGISTER_WIDTH each  issued operands.
- `aluout_in`  in  REGISTER_WIDTH  ALU result.
- `carry_in`  in  1  ALU carry.
- `res_valid`  out  1  result valid this cycle.
- `res_rd`  out  5  destination of the result.
- `res_data`  out  REGISTER_WIDTH  equal to `aluout_in`.
- `res_carry`  out  1  equal to `carry_in`.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FIFO non-empty or any operation in flight.

## Operation
- **FIFO**
  - Write pointer, read pointer and count registers.
  - `in_ready = (count < DEPTH)`, computed from registered state only. A pop in the same cycle does not raise `in_ready`.
  - Push when `in_valid && in_ready && !flush`.
- **In-flight tracker**
  - LATENCY-stage shift register; each stage holds `{v, rd}`.
  - On an issue, stage 0 loads `{1, head.rd}`. Otherwise stage 0 loads `v=0`.
  - Each stage shifts by one per cycle, unconditionally.
- **Hazard check**
  - The head is blocked if any stage with `v=1` and `rd != 0` matches `head.rs1` (when `in_rs_used[0]`) or `head.rs2` (when `in_rs_used[1]`).
  - Register 0 never causes a hazard.
- **Issue**
  - Issue when FIFO non-empty, not blocked, and `!flush`.
  - `enable_ex` is combinational from registered state.
  - `control_out`, `src1_out`, `src2_out` and `imm_out` show the head entry while issuing. Otherwise they hold the last issued values (zero after reset).
  - Issue pops the head.
- **Results**
  - `res_valid` = `v` of the last tracker stage.
  - `res_rd` = `rd` of the last tracker stage.
  - `res_data` and `res_carry` are pass-through.
- **Flush** (highest priority, above push and issue)
  - Count and pointers reset to 0.
  - All tracker `v` bits clear at the next edge.
  - `res_valid` is still honoured in the flush cycle itself.
- **Occupancy**
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
- **Reset**
  - FIFO empty; tracker cleared; `enable_ex`=0.
  - `control_out`, `src*_out`, `imm_out` = 0.
  - `res_valid`=0, `res_rd`=0, `count`=0, `busy`=0.
  - Reset asserted mid-operation discards everything immediately (asynchronous); no result is reported afterwards.

## Timing
- Operation accepted at edge E is eligible to issue in the cycle after E. There is no FIFO bypass.
- Issue in cycle N means `res_valid`=1 in cycle N+LATENCY.
- Back-to-back independent operations give one issue and one result per cycle.
- Dependent operation (rs matches rd of an operation issued in cycle N) issues no earlier than cycle N+LATENCY+1.
  - With LATENCY=2 this is a 2-cycle bubble.
  - Result writeback and forwarding are the consumer's responsibility.
- Full FIFO: `in_ready`=0 during the whole cycle. A push offered while full is not accepted and must be held by the requester.
- Empty FIFO: `enable_ex`=0.

## Test plan
- **Reset values:** assert `reset`=0 for 3 cycles with `in_valid`=1 → `in_ready`=1 after release; all outputs 0, `busy`=0.
- **Streaming:** push 4 independent ADDs (rd=1..4, src1=5, src2=7) on consecutive cycles → `enable_ex` on cycles 1..4; `res_valid` on cycles 3..6 with `res_rd`=1,2,3,4 in order.
- **RAW hazard:** op A rd=3, then op B rs1=3 (rs_used=01) → B issues 3 cycles after A. An op with rs1=0 and rd=0 on both sides never stalls.
- **Full/wrap:** hold the head blocked, push 5 ops → 5th stalls with `in_ready`=0 and `count`=4. Unblock → all 5 results arrive in order across pointer wrap.
- **Flush:** flush one cycle after issuing 2 ops with 2 queued → `count`=0 next cycle, no further `res_valid`, `busy`=0.
- **Async reset mid-flight:** pull `reset` low mid-cycle during an issue → outputs clear without waiting for an edge; no result appears after release.

Source files
------------

// File: rtl/exec_issue_ctrl.sv
// Issue controller for the execute datapath: queues decoded ops, stalls on RAW
// hazards against in-flight ops, and tags ALU results with their destination.
module exec_issue_ctrl #(
  parameter int DEPTH          = 4,
  parameter int LATENCY        = 2,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_control,
  input  logic [REGISTER_WIDTH-1:0]   in_src1,
  input  logic [REGISTER_WIDTH-1:0]   in_src2,
  input  logic [REGISTER_WIDTH-1:0]   in_imm,
  input  logic [4:0]                  in_rd,
  input  logic [4:0]                  in_rs1,
  input  logic [4:0]                  in_rs2,
  input  logic [1:0]                  in_rs_used,
  output logic                        enable_ex,
  output logic [6:0]                  control_out,
  output logic [REGISTER_WIDTH-1:0]   src1_out,
  output logic [REGISTER_WIDTH-1:0]   src2_out,
  output logic [REGISTER_WIDTH-1:0]   imm_out,
  input  logic [REGISTER_WIDTH-1:0]   aluout_in,
  input  logic                        carry_in,
  output logic                        res_valid,
  output logic [4:0]                  res_rd,
  output logic [REGISTER_WIDTH-1:0]   res_data,
  output logic                        res_carry,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [6:0]                ctl;
    logic [REGISTER_WIDTH-1:0] src1;
    logic [REGISTER_WIDTH-1:0] src2;
    logic [REGISTER_WIDTH-1:0] imm;
    logic [4:0]                rd;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [1:0]                rs_used;
  } entry_t;

  entry_t                    mem_q [DEPTH];
  entry_t                    mem_d [DEPTH];
  entry_t                    in_entry;
  entry_t                    head;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [LATENCY-1:0]        trk_v_q, trk_v_d;
  logic [4:0]                trk_rd_q [LATENCY];
  logic [4:0]                trk_rd_d [LATENCY];
  logic [6:0]                ctl_last_q, ctl_last_d;
  logic [REGISTER_WIDTH-1:0] src1_last_q, src1_last_d;
  logic [REGISTER_WIDTH-1:0] src2_last_q, src2_last_d;
  logic [REGISTER_WIDTH-1:0] imm_last_q, imm_last_d;
  logic                      empty, blocked, push, issue;

  assign head     = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready && !flush;
  assign issue    = !empty && !blocked && !flush;

  // Register 0 is hardwired, so an in-flight write to it never blocks a reader.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      if (trk_v_q[i] && (trk_rd_q[i] != 5'd0)) begin
        if (head.rs_used[0] && (head.rs1 == trk_rd_q[i])) blocked = 1'b1;
        if (head.rs_used[1] && (head.rs2 == trk_rd_q[i])) blocked = 1'b1;
      end
    end
  end

  always_comb begin
    in_entry.ctl     = in_control;
    in_entry.src1    = in_src1;
    in_entry.src2    = in_src2;
    in_entry.imm     = in_imm;
    in_entry.rd      = in_rd;
    in_entry.rs1     = in_rs1;
    in_entry.rs2     = in_rs2;
    in_entry.rs_used = in_rs_used;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_entry;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    trk_v_d     = '0;
    trk_rd_d[0] = 5'd0;
    if (!flush) begin
      trk_v_d[0]  = issue;
      trk_rd_d[0] = issue ? head.rd : 5'd0;
    end
    for (int i = 1; i < LATENCY; i++) begin
      trk_v_d[i]  = flush ? 1'b0 : trk_v_q[i-1];
      trk_rd_d[i] = flush ? 5'd0 : trk_rd_q[i-1];
    end
  end

  always_comb begin
    ctl_last_d  = ctl_last_q;
    src1_last_d = src1_last_q;
    src2_last_d = src2_last_q;
    imm_last_d  = imm_last_q;
    if (issue) begin
      ctl_last_d  = head.ctl;
      src1_last_d = head.src1;
      src2_last_d = head.src2;
      imm_last_d  = head.imm;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      trk_v_q     <= '0;
      for (int i = 0; i < LATENCY; i++) trk_rd_q[i] <= 5'd0;
      ctl_last_q  <= '0;
      src1_last_q <= '0;
      src2_last_q <= '0;
      imm_last_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      trk_v_q     <= trk_v_d;
      for (int i = 0; i < LATENCY; i++) trk_rd_q[i] <= trk_rd_d[i];
      ctl_last_q  <= ctl_last_d;
      src1_last_q <= src1_last_d;
      src2_last_q <= src2_last_d;
      imm_last_q  <= imm_last_d;
    end
  end

  // Queue storage carries only data; validity lives in the count/pointers.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign enable_ex   = issue;
  assign control_out = issue ? head.ctl  : ctl_last_q;
  assign src1_out    = issue ? head.src1 : src1_last_q;
  assign src2_out    = issue ? head.src2 : src2_last_q;
  assign imm_out     = issue ? head.imm  : imm_last_q;
  assign res_valid   = trk_v_q[LATENCY-1];
  assign res_rd      = trk_rd_q[LATENCY-1];
  assign res_data    = aluout_in;
  assign res_carry   = carry_in;
  assign count       = count_q;
  assign busy        = !empty || (|trk_v_q);

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Scoreboard bench for exec_issue_ctrl: directed ops with hand-computed issue and
// result cycles; a negedge monitor pops expectations whenever the DUT presents output.
module tb_exec_issue_ctrl;
  localparam int RW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_control = '0;
  logic [RW-1:0] in_src1 = '0, in_src2 = '0, in_imm = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [1:0]    in_rs_used = '0;
  logic          enable_ex;
  logic [6:0]    control_out;
  logic [RW-1:0] src1_out, src2_out, imm_out;
  logic [RW-1:0] aluout_in;
  logic          carry_in;
  logic          res_valid;
  logic [4:0]    res_rd;
  logic [RW-1:0] res_data;
  logic          res_carry;
  logic [2:0]    count;
  logic          busy;

  exec_issue_ctrl #(.DEPTH(4), .LATENCY(2), .REGISTER_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs_used(in_rs_used),
    .enable_ex(enable_ex), .control_out(control_out), .src1_out(src1_out),
    .src2_out(src2_out), .imm_out(imm_out), .aluout_in(aluout_in), .carry_in(carry_in),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_carry(res_carry),
    .count(count), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  assign aluout_in = 32'hA5A5_0000 ^ 32'(cyc);
  assign carry_in  = cyc[0];

  typedef struct {
    logic [6:0]    ctl;
    logic [RW-1:0] s1, s2, imm;
    int            cy;
  } iss_t;
  typedef struct {
    logic [4:0] rd;
    int         cy;
  } res_t;

  iss_t iq[$];
  res_t rq[$];
  iss_t mon_i;
  res_t mon_r;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_issue(input logic [6:0] c, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                           input logic [RW-1:0] imm, input int cy);
    iss_t e;
    e.ctl = c; e.s1 = s1; e.s2 = s2; e.imm = imm; e.cy = cy;
    iq.push_back(e);
  endtask

  task automatic exp_res(input logic [4:0] rd, input int cy);
    res_t e;
    e.rd = rd; e.cy = cy;
    rq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (enable_ex) begin
        if (iq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL issue_unexpected: enable_ex=1 ctl=%0h, expected no issue (cycle %0d)",
                   control_out, cyc);
        end else begin
          mon_i = iq.pop_front();
          check("issue_data", {control_out, src1_out, src2_out, imm_out},
                {mon_i.ctl, mon_i.s1, mon_i.s2, mon_i.imm});
          check("issue_cycle", cyc, mon_i.cy);
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL result_unexpected: res_valid=1 res_rd=%0d, expected none (cycle %0d)",
                   res_rd, cyc);
        end else begin
          mon_r = rq.pop_front();
          check("res_rd", res_rd, mon_r.rd);
          check("res_cycle", cyc, mon_r.cy);
          check("res_pass", {res_data, res_carry}, {aluout_in, carry_in});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic push_op(input logic [6:0] c, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                         input logic [RW-1:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [1:0] used, output int acc);
    int  i;
    bit  done;
    in_control = c; in_src1 = s1; in_src2 = s2; in_imm = imm;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_rs_used = used;
    in_valid = 1'b1;
    acc = -1; done = 1'b0; i = 0;
    while (!done && i < 20) begin
      @(negedge clock);
      if (in_ready && !flush) begin
        acc = cyc;
        done = 1'b1;
      end
      i++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0, expected acceptance (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_idle();
    int i;
    bit done;
    done = 1'b0; i = 0;
    while (!done && i < 60) begin
      @(negedge clock);
      if (!busy) done = 1'b1;
      i++;
    end
    check("drain_busy", busy, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int a, acc;

    // Reset with a request pending
    reset = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_enable_ex", enable_ex, 1'b0);
    check("rst_control_out", control_out, 7'd0);
    check("rst_operands", {src1_out, src2_out, imm_out}, 96'd0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_rd", res_rd, 5'd0);
    check("rst_count", count, 3'd0);
    check("rst_busy", busy, 1'b0);
    @(posedge clock);
    #1;

    // Streaming independent ops
    push_op(7'h11, 32'd5, 32'd7, 32'd1, 5'd1, 5'd0, 5'd0, 2'b11, a);
    exp_issue(7'h11, 32'd5, 32'd7, 32'd1, a + 1);
    exp_res(5'd1, a + 3);
    for (int k = 2; k <= 4; k++) begin
      push_op(7'(16 + k), 32'd5, 32'd7, 32'(k), 5'(k), 5'd0, 5'd0, 2'b11, acc);
      check("stream_accept", acc, a + k - 1);
      exp_issue(7'(16 + k), 32'd5, 32'd7, 32'(k), a + k);
      exp_res(5'(k), a + k + 2);
    end
    wait_idle();
    check("hold_last_issue", {control_out, src1_out, src2_out, imm_out},
          {7'h14, 32'd5, 32'd7, 32'd4});

    // RAW hazard on rs1
    push_op(7'h21, 32'd1, 32'd2, 32'd3, 5'd3, 5'd0, 5'd0, 2'b00, a);
    exp_issue(7'h21, 32'd1, 32'd2, 32'd3, a + 1);
    exp_res(5'd3, a + 3);
    push_op(7'h22, 32'd4, 32'd5, 32'd6, 5'd8, 5'd3, 5'd0, 2'b01, acc);
    check("raw_accept", acc, a + 1);
    exp_issue(7'h22, 32'd4, 32'd5, 32'd6, a + 4);
    exp_res(5'd8, a + 6);
    wait_idle();

    // Register 0 never stalls
    push_op(7'h23, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd0, 2'b00, a);
    exp_issue(7'h23, 32'd1, 32'd1, 32'd0, a + 1);
    exp_res(5'd0, a + 3);
    push_op(7'h24, 32'd2, 32'd2, 32'd0, 5'd9, 5'd0, 5'd0, 2'b01, acc);
    check("r0_accept", acc, a + 1);
    exp_issue(7'h24, 32'd2, 32'd2, 32'd0, a + 2);
    exp_res(5'd9, a + 4);
    wait_idle();

    // Unused rs2 ignored, used rs2 stalls
    push_op(7'h25, 32'd10, 32'd11, 32'd12, 5'd5, 5'd0, 5'd0, 2'b00, a);
    exp_issue(7'h25, 32'd10, 32'd11, 32'd12, a + 1);
    exp_res(5'd5, a + 3);
    push_op(7'h26, 32'd13, 32'd14, 32'd15, 5'd6, 5'd9, 5'd5, 2'b01, acc);
    check("rs2_unused_accept", acc, a + 1);
    exp_issue(7'h26, 32'd13, 32'd14, 32'd15, a + 2);
    exp_res(5'd6, a + 4);
    push_op(7'h27, 32'd16, 32'd17, 32'd18, 5'd7, 5'd0, 5'd5, 2'b10, acc);
    check("rs2_used_accept", acc, a + 2);
    exp_issue(7'h27, 32'd16, 32'd17, 32'd18, a + 4);
    exp_res(5'd7, a + 6);
    wait_idle();

    // Dependency chain fills the queue and wraps the pointers
    push_op(7'h31, 32'd101, 32'd201, 32'd1, 5'd1, 5'd0, 5'd0, 2'b01, a);
    for (int k = 1; k <= 7; k++) begin
      exp_issue(7'(48 + k), 32'(100 + k), 32'(200 + k), 32'(k), a + 1 + 3 * (k - 1));
      exp_res(5'(k), a + 3 + 3 * (k - 1));
    end
    for (int k = 2; k <= 6; k++) begin
      push_op(7'(48 + k), 32'(100 + k), 32'(200 + k), 32'(k), 5'(k), 5'(k - 1), 5'd0, 2'b01, acc);
      check("chain_accept", acc, a + k - 1);
    end
    @(negedge clock);
    check("full_count", count, 3'd4);
    check("full_in_ready", in_ready, 1'b0);
    push_op(7'h37, 32'd107, 32'd207, 32'd7, 5'd7, 5'd6, 5'd0, 2'b01, acc);
    check("full_accept", acc, a + 8);
    wait_idle();

    // Flush with ops in flight and queued
    push_op(7'h41, 32'd1, 32'd1, 32'd1, 5'd12, 5'd0, 5'd0, 2'b00, a);
    exp_issue(7'h41, 32'd1, 32'd1, 32'd1, a + 1);
    exp_res(5'd12, a + 3);
    push_op(7'h42, 32'd2, 32'd2, 32'd2, 5'd13, 5'd12, 5'd0, 2'b01, acc);
    check("flush_accept_b", acc, a + 1);
    exp_issue(7'h42, 32'd2, 32'd2, 32'd2, a + 4);
    exp_res(5'd13, a + 6);
    push_op(7'h43, 32'd3, 32'd3, 32'd3, 5'd14, 5'd0, 5'd0, 2'b00, acc);
    check("flush_accept_c", acc, a + 2);
    exp_issue(7'h43, 32'd3, 32'd3, 32'd3, a + 5);
    push_op(7'h44, 32'd4, 32'd4, 32'd4, 5'd15, 5'd0, 5'd0, 2'b00, acc);
    check("flush_accept_d", acc, a + 3);
    push_op(7'h45, 32'd5, 32'd5, 32'd5, 5'd16, 5'd0, 5'd0, 2'b00, acc);
    check("flush_accept_e", acc, a + 4);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_count", count, 3'd0);
    check("flush_busy", busy, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    repeat (5) @(negedge clock);
    @(posedge clock);
    #1;

    // Asynchronous reset during an issue
    push_op(7'h55, 32'hDEAD_BEEF, 32'd1, 32'd2, 5'd20, 5'd0, 5'd0, 2'b00, a);
    #1;
    check("pre_reset_issue", {enable_ex, control_out, src1_out}, {1'b1, 7'h55, 32'hDEAD_BEEF});
    #1;
    reset = 1'b0;
    #1;
    check("async_enable_ex", enable_ex, 1'b0);
    check("async_outputs", {control_out, src1_out, src2_out, imm_out}, 103'd0);
    check("async_state", {count, busy, res_valid, res_rd}, 10'd0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("post_reset_res_valid", res_valid, 1'b0);
    end

    check("leftover_issue_exp", iq.size(), 0);
    check("leftover_result_exp", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
